// File: rtl/lsu_axi_master.sv
// Load/store bus master: core request to AXI-lite AW/W/B or AR/R.
// Optional LSU_MISALIGN_CHECK_EN faults misaligned half/word accesses.
module lsu_axi_master #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESETN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [31:0]           REQ_ADDR,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [AXI_AWIDTH-1:0] AXI_AWADDR,
  output logic                  AXI_AWVALID,
  input  logic                  AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0] AXI_WDATA,
  output logic [3:0]            AXI_WSTRB,
  output logic                  AXI_WVALID,
  input  logic                  AXI_WREADY,
  input  logic [1:0]            AXI_BRESP,
  input  logic                  AXI_BVALID,
  output logic                  AXI_BREADY,
  output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t state_q, state_d;
  logic [1:0] off_q, off_d, size_q, size_d;
  logic uns_q, uns_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic err_q, err_d;

  logic misalign;
  logic [31:0] lane_data, rd_sh, rd_ext;
  logic [3:0] lane_strb;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic unused_addr;

  assign unused_addr = ^REQ_ADDR[31:AXI_AWIDTH+2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (REQ_SIZE == 2'b01 && REQ_ADDR[0]) ||
                    (REQ_SIZE[1] && REQ_ADDR[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    lane_data = REQ_WDATA;
    lane_strb = 4'b1111;
    unique case (1'b1)
      REQ_SIZE == 2'b00: begin
        lane_data = {4{REQ_WDATA[7:0]}};
        lane_strb = 4'b0001 << REQ_ADDR[1:0];
      end
      REQ_SIZE == 2'b01: begin
        lane_data = {2{REQ_WDATA[15:0]}};
        lane_strb = 4'b0011 << {REQ_ADDR[1], 1'b0};
      end
      default: ;
    endcase
  end

  // word loads never shift; half loads only use the upper address bit
  always_comb begin
    rd_sh  = AXI_RDATA;
    rd_ext = AXI_RDATA;
    unique case (1'b1)
      size_q == 2'b00: begin
        rd_sh  = AXI_RDATA >> {off_q, 3'b000};
        rd_ext = {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]};
      end
      size_q == 2'b01: begin
        rd_sh  = AXI_RDATA >> {off_q[1], 4'b0000};
        rd_ext = {{16{~uns_q & rd_sh[15]}}, rd_sh[15:0]};
      end
      default: ;
    endcase
  end

  assign aw_hs = awvalid_q & AXI_AWREADY;
  assign w_hs  = wvalid_q & AXI_WREADY;
  assign b_hs  = bready_q & AXI_BVALID & ~b_done_q;
  assign ar_hs = arvalid_q & AXI_ARREADY;
  assign r_hs  = rready_q & AXI_RVALID;

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    b_done_d  = b_done_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: if (REQ_VALID) begin
        off_d     = REQ_ADDR[1:0];
        size_d    = REQ_SIZE;
        uns_d     = REQ_UNSIGNED;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        b_done_d  = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        if (misalign) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (REQ_WE) begin
          awaddr_d  = REQ_ADDR[AXI_AWIDTH+1:2];
          wdata_d   = lane_data;
          wstrb_d   = lane_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
          state_d   = WRITE;
        end else begin
          araddr_d  = REQ_ADDR[AXI_AWIDTH+1:2];
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          state_d   = READ;
        end
      end
      WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (b_hs) begin
          b_done_d = 1'b1;
          err_d    = |AXI_BRESP;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs) && (b_done_q | b_hs)) begin
          bready_d = 1'b0;
          state_d  = DONE;
        end
      end
      READ: begin
        if (ar_hs) arvalid_d = 1'b0;
        if (r_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          err_d     = |AXI_RRESP;
          rdata_d   = (|AXI_RRESP) ? 32'h0 : rd_ext;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state_q   <= IDLE;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      b_done_q  <= b_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign REQ_READY   = (state_q == IDLE);
  assign RSP_VALID   = (state_q == DONE);
  assign RSP_RDATA   = rdata_q;
  assign RSP_ERR     = err_q;
  assign AXI_AWADDR  = awaddr_q;
  assign AXI_AWVALID = awvalid_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = wstrb_q;
  assign AXI_WVALID  = wvalid_q;
  assign AXI_BREADY  = bready_q;
  assign AXI_ARADDR  = araddr_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master; slave handshakes driven step by step.
// Build with LSU_MISALIGN_CHECK_EN to cover the misalign fault path.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_axi_master #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_SIZE(req_size),
    .REQ_UNSIGNED(req_unsigned), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid),
    .AXI_WREADY(wready), .AXI_BRESP(bresp), .AXI_BVALID(bvalid),
    .AXI_BREADY(bready), .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid),
    .AXI_ARREADY(arready), .AXI_RDATA(rdata), .AXI_RRESP(rresp),
    .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_clear();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic u,
                       input logic [31:0] d);
    req_we = we; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = d; req_valid = 1;
    tick();
    req_valid = 0;
  endtask

  task automatic store0(input string tag, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] d,
                        input logic [3:0] exp_aw, input logic [31:0] exp_wd,
                        input logic [3:0] exp_st);
    issue(1, a, sz, 0, d);
    chk({tag, " awaddr"}, {28'h0, awaddr}, {28'h0, exp_aw});
    chk({tag, " wdata"}, wdata, exp_wd);
    chk({tag, " wstrb"}, {28'h0, wstrb}, {28'h0, exp_st});
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    tick();
    slave_clear();
    chk({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, " rsp_err"}, {31'h0, rsp_err}, 32'h0);
    tick();
  endtask

  task automatic load0(input string tag, input logic [31:0] a,
                       input logic [1:0] sz, input logic u,
                       input logic [31:0] rd, input logic [3:0] exp_ar,
                       input logic [31:0] exp);
    issue(0, a, sz, u, 0);
    chk({tag, " araddr"}, {28'h0, araddr}, {28'h0, exp_ar});
    chk({tag, " arvalid/rready"}, {30'h0, arvalid, rready}, 32'h3);
    arready = 1; rvalid = 1; rdata = rd; rresp = 0;
    tick();
    slave_clear();
    chk({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp);
    chk({tag, " rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({tag, " rready low"}, {31'h0, rready}, 32'h0);
    tick();
  endtask

  initial begin
    rst_n = 0;
    req_valid = 0; req_we = 0; req_addr = 0; req_size = 0;
    req_unsigned = 0; req_wdata = 0;
    slave_clear();
    tick();
    tick();
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("rst rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst wstrb/addr", {24'h0, wstrb, awaddr}, 32'h0);
    rst_n = 1;
    tick();

    // SW 0x8, zero-wait, three cycles accept->idle
    issue(1, 32'h8, 2'b10, 0, 32'hDEADBEEF);
    chk("sw awaddr", {28'h0, awaddr}, 32'h2);
    chk("sw wdata", wdata, 32'hDEADBEEF);
    chk("sw wstrb", {28'h0, wstrb}, 32'hF);
    chk("sw valids", {29'h0, awvalid, wvalid, bready}, 32'h7);
    chk("sw req_ready busy", {31'h0, req_ready}, 32'h0);
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    tick();
    slave_clear();
    chk("sw rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("sw rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("sw rsp_rdata", rsp_rdata, 32'h0);
    chk("sw done req_ready", {31'h0, req_ready}, 32'h0);
    chk("sw done valids", {29'h0, awvalid, wvalid, bready}, 32'h0);
    tick();
    chk("sw pulse end", {31'h0, rsp_valid}, 32'h0);
    chk("sw idle", {31'h0, req_ready}, 32'h1);

    store0("sb", 32'h5, 2'b00, 32'h000000A5, 4'h1, 32'hA5A5A5A5, 4'b0010);
    store0("sh", 32'h2, 2'b01, 32'h1234BEEF, 4'h0, 32'hBEEFBEEF, 4'b1100);

    load0("lb", 32'h6, 2'b00, 0, 32'h12F03456, 4'h1, 32'hFFFFFFF0);
    load0("lbu", 32'h6, 2'b00, 1, 32'h12F03456, 4'h1, 32'h000000F0);
    load0("lh", 32'h2, 2'b01, 0, 32'h80010000, 4'h0, 32'hFFFF8001);
    load0("lhu", 32'h2, 2'b01, 1, 32'h80010000, 4'h0, 32'h00008001);

    // W at cycle 1, B early at cycle 2, AW at cycle 4
    issue(1, 32'hC, 2'b10, 0, 32'h11223344);
    wready = 1;
    tick();
    wready = 0;
    chk("dly wvalid drop", {31'h0, wvalid}, 32'h0);
    chk("dly awvalid c1", {31'h0, awvalid}, 32'h1);
    chk("dly awaddr c1", {28'h0, awaddr}, 32'h3);
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0; bresp = 0;
    chk("dly bready held", {31'h0, bready}, 32'h1);
    chk("dly no rsp early", {31'h0, rsp_valid}, 32'h0);
    chk("dly awvalid c2", {31'h0, awvalid}, 32'h1);
    tick();
    chk("dly awaddr c3", {28'h0, awaddr}, 32'h3);
    chk("dly wdata c3", wdata, 32'h11223344);
    chk("dly aw/w c3", {30'h0, awvalid, wvalid}, 32'h2);
    awready = 1;
    tick();
    awready = 0;
    chk("dly rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("dly rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("dly bus idle", {29'h0, awvalid, wvalid, bready}, 32'h0);
    tick();

`ifdef LSU_MISALIGN_CHECK_EN
    issue(0, 32'h6, 2'b10, 0, 0);
    chk("lw mis arvalid", {31'h0, arvalid}, 32'h0);
    chk("lw mis rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("lw mis rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("lw mis rsp_rdata", rsp_rdata, 32'h0);
    tick();
    chk("lw mis idle", {31'h0, req_ready}, 32'h1);
`else
    load0("lw 0x6", 32'h6, 2'b10, 0, 32'hCAFEF00D, 4'h1, 32'hCAFEF00D);
`endif

    // reset while a read is outstanding
    issue(0, 32'h4, 2'b10, 0, 0);
    chk("rr arvalid", {31'h0, arvalid}, 32'h1);
    rst_n = 0;
    tick();
    chk("rr ar/r low", {30'h0, arvalid, rready}, 32'h0);
    chk("rr no rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rr req_ready", {31'h0, req_ready}, 32'h1);
    rst_n = 1;
    tick();
    chk("rr still no rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rr idle", {31'h0, req_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
